// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer: state encoding, byte width,
// and a one-hot helper used to validate chip-select requests.
package spi_seq_pkg;

    localparam int SPI_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_BSY  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_HOLD      = 3'd5
    } seq_state_t;

    // Callers zero-extend their vector to 32 bits, so CS_NUM is limited to 32.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous show-ahead FIFO. A push on full is dropped unless a pop happens in
// the same cycle; a pop on empty is ignored.
module spi_seq_fifo
    import spi_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = SPI_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide, so wrap modulo DEPTH falls out naturally.
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_wr && !do_rd)      count_d = count_q + (AW+1)'(1);
        else if (!do_wr && do_rd) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI transaction sequencer: owns chip-select, feeds the single-byte
// engine from a TX FIFO and collects received bytes into an RX FIFO.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int LEN_W        = 8,
    parameter int CS_NUM       = 8,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_wr_en,
    input  logic [SPI_W-1:0]  tx_wr_data,
    output logic              tx_full,
    input  logic              rx_rd_en,
    output logic [SPI_W-1:0]  rx_rd_data,
    output logic              rx_empty,
    input  logic              go,
    input  logic              abort,
    input  logic [LEN_W-1:0]  xfer_len,
    input  logic [CS_NUM-1:0] cs_sel,
    output logic              seq_busy,
    output logic              seq_done,
    output logic              rx_ovf,
    output logic              spi_start,
    output logic [SPI_W-1:0]  spi_tx_data,
    input  logic              spi_busy,
    input  logic              spi_new_data,
    input  logic [SPI_W-1:0]  spi_rx_data,
    output logic [CS_NUM-1:0] spi_cs_n
);

    localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CS_NUM-1:0] cs_n_q, cs_n_d;
    logic              seq_done_q, seq_done_d;
    logic              rx_ovf_q, rx_ovf_d;
    logic [SPI_W-1:0]  tx_data_q, tx_data_d;

    logic              tx_pop, tx_empty, rx_push, rx_full;
    logic [SPI_W-1:0]  tx_head;
    logic [FCNT_W-1:0] tx_cnt, rx_cnt;
    logic              unused_cnt;

    spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(SPI_W)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (tx_wr_en),
        .wr_data (tx_wr_data),
        .rd_en   (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_cnt)
    );

    spi_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(SPI_W)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (rx_push),
        .wr_data (spi_rx_data),
        .rd_en   (rx_rd_en),
        .rd_data (rx_rd_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_cnt)
    );

    assign unused_cnt = ^{tx_cnt, rx_cnt};

    assign seq_busy = (state_q != ST_IDLE);
    assign seq_done = seq_done_q;
    assign rx_ovf   = rx_ovf_q;
    assign spi_cs_n = cs_n_q;
    // The head byte goes out in the start cycle itself; afterwards the latched copy holds it.
    assign spi_tx_data = (state_q == ST_LOAD) ? tx_head : tx_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        cs_n_d     = cs_n_q;
        seq_done_d = 1'b0;
        rx_ovf_d   = rx_ovf_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        spi_start  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (go && !spi_busy) begin
                    rx_ovf_d = 1'b0;
                    rem_d    = xfer_len;
                    cnt_d    = '0;
                    // Empty or malformed requests complete without touching CS.
                    if (xfer_len == '0 || !is_onehot(32'(cs_sel))) begin
                        seq_done_d = 1'b1;
                    end else begin
                        cs_n_d  = ~cs_sel;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    spi_start = 1'b1;
                    tx_data_d = tx_head;
                    state_d   = ST_WAIT_BSY;
                end
            end
            ST_WAIT_BSY, ST_WAIT_DONE: begin
                // A fast engine may finish before busy is ever observed.
                if (spi_new_data) begin
                    rx_push = 1'b1;
                    if (rx_full && !rx_rd_en) rx_ovf_d = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1) || abort) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (state_q == ST_WAIT_BSY && spi_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD_CYC - 1)) begin
                    cs_n_d     = '1;
                    seq_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cs_n_d  = '1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            cs_n_q     <= '1;
            seq_done_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            cs_n_q     <= cs_n_d;
            seq_done_q <= seq_done_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule
